uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Parameterised successor to the single-byte memory-mapped UART. Adds RX/TX FIFOs of configurable depth, 5–8 data bits, sticky error flags and a maskable level interrupt. Sits on the CPU memory bus as a peripheral, with the same select/read/write-mask/ready protocol and a single-cycle response.

Parameters:
FIFO_DEPTH, 16, entries per RX and TX FIFO; power of two, >=2
DEFAULT_CLK_DIV, 16'd103, clk_div value after reset
DATA_BITS_RESET, 8, data-bits field value after reset (5..8)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_in  input  1  serial receive line, idle high
tx_out  output  1  serial transmit line, idle high
irq_out  output  1  level interrupt to the CPU
address_in  input  32  bus address; bits [3:2] select the register
sel_in  input  1  peripheral select
read_in  input  1  read strobe
read_value_out  output  32  combinational read data; 0 when sel_in=0
write_mask_in  input  4  byte write enables
write_value_in  input  32  write data
ready_out  output  1  equals sel_in (single-cycle access)

Behaviour:
- Reset values:
  - tx_out=1, irq_out=0
  - Both FIFOs empty; all sticky flags 0
  - clk_div=DEFAULT_CLK_DIV; CTRL=0 except data_bits=DATA_BITS_RESET
  - RX and TX engines idle
- Reset mid-frame aborts the frame immediately; tx_out returns to 1 asynchronously.
- Register map, selected by address_in[3:2]:
  - 0 CLK_DIV: [15:0], byte-masked write.
  - 1 STATUS, read:
    - [0] tx_empty (FIFO empty and shifter idle)
    - [1] tx_full
    - [2] rx_nonempty
    - [3] rx_full
    - [4] rx_overrun
    - [5] frame_err
    - [6] tx_overflow
    - [7] parity_err
    - [15:8] rx_count
    - Write: bits [7:4] are write-1-to-clear, mask byte 0.
  - 2 DATA:
    - Read returns {24'h0, head} if RX is nonempty, otherwise 32'hFFFFFFFF.
    - Read with sel_in&read_in pops one RX entry at the clock edge.
    - Write with mask[0] pushes write_value_in[7:0] to TX.
  - 3 CTRL:
    - [0] rx_ie, [1] tx_ie, [2] err_ie
    - [4:3] data_bits-5
    - [5] parity_en, [6] parity_odd
    - Byte 0 mask.
- Bit period is clk_div+1 clocks.
- TX engine:
  - Idle with FIFO nonempty: pops the head and drives the start bit on the next cycle.
  - Frame order: start(0), data LSB first (data_bits bits), optional parity, stop(1).
  - Back-to-back bytes follow with no idle gap.
- RX engine:
  - Idle: a sampled rx_in=0 loads half a bit period, then re-samples.
  - If the line is high at the start-bit centre, the event is a glitch and the engine returns to idle.
  - Data, parity and stop bits are sampled at bit centres.
  - Stop bit = 0: byte is discarded, frame_err is set, and the engine waits for rx_in=1 before re-arming.
- Writing a byte to RX with data_bits<8 zero-extends it.
- FIFO rules:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Push and pop together leave the count unchanged.
- RX push when full, with no pop that cycle: byte dropped, rx_overrun=1.
- TX write when full: byte dropped, tx_overflow=1.
- A DATA read on an empty RX does not change state.
- A new byte arriving the same cycle as a read of an empty RX: the read returns 32'hFFFFFFFF and the byte is stored.
- W1C clear and a set event in the same cycle: set wins.
- CLK_DIV written mid-frame takes effect at the next bit-period reload.
- irq_out is registered:
  - irq_out = (rx_ie & rx_nonempty) | (tx_ie & tx_empty) | (err_ie & |flags[7:4]).
  - It updates one cycle after the cause.

Optional Feature:
Macro UART_PARITY_EN.
- Defined:
  - CTRL[6:5] are implemented.
  - With parity_en=1, a parity bit is transmitted after the data bits: even parity, or odd when parity_odd=1.
  - A received parity mismatch sets parity_err sticky; the byte is still stored.
- Undefined:
  - No parity hardware; CTRL[6:5] and STATUS[7] read 0 and writes to them are ignored.
  - Frames are always start+data+stop.

Test Plan:
1. clk_div=3, 8N1, write DATA=0x55 → tx_out start bit 0, then 1,0,1,0,1,0,1,0, then stop 1; each bit 4 clocks wide; STATUS[0] returns to 1 after the stop bit.
2. Drive an rx_in frame carrying 0xA3 at clk_div=3 → STATUS[2]=1; DATA read returns 0x000000A3; a second read returns 0xFFFFFFFF.
3. Receive FIFO_DEPTH+1 bytes without reading → rx_full=1, rx_overrun=1; the first FIFO_DEPTH bytes read back in order; write STATUS=0x10 clears rx_overrun.
4. Frame with stop bit 0 → frame_err=1, nothing pushed; with err_ie=1, irq_out=1 one cycle later.
5. data_bits=5 (CTRL[4:3]=0), send 0x1F → 7-bit frame on tx_out; loopback to rx_in reads 0x0000001F.
6. UART_PARITY_EN defined, CTRL parity_en=1 and odd, loopback 0x07 → parity bit 0; a forced bad parity bit sets STATUS[7] and the byte is still stored; assert reset mid-frame → tx_out=1 and FIFOs empty immediately.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped UART with RX/TX FIFOs, 5..8 data bits, sticky
// error flags and a maskable registered level interrupt.
// Optional parity hardware is built when UART_PARITY_EN is defined.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   rx_in / tx_out                      serial lines, idle high
//   irq_out                             registered level interrupt
//   address_in[3:2]                     register select (CLK_DIV/STATUS/DATA/CTRL)
//   sel_in, read_in, write_mask_in,
//   write_value_in                      bus request
//   read_value_out                      combinational read data (0 when !sel_in)
//   ready_out                           mirrors sel_in
module uart_fifo #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter logic [15:0] DEFAULT_CLK_DIV = 16'd103,
  parameter int unsigned DATA_BITS_RESET = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        irq_out,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

  // Bus decode
  logic [1:0] reg_sel;
  logic       wr_status, wr_ctrl, data_rd, data_wr;
  assign reg_sel   = address_in[3:2];
  assign ready_out = sel_in;
  assign wr_status = sel_in && reg_sel == 2'd1 && write_mask_in[0];
  assign data_rd   = sel_in && reg_sel == 2'd2 && read_in;
  assign data_wr   = sel_in && reg_sel == 2'd2 && write_mask_in[0];
  assign wr_ctrl   = sel_in && reg_sel == 2'd3 && write_mask_in[0];

  // Configuration registers
  logic [15:0] clk_div;
  logic        rx_ie, tx_ie, err_ie, parity_en, parity_odd;
  logic [1:0]  dbm5;
  logic [2:0]  dbm1;
  assign dbm1 = 3'(dbm5) + 3'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_div <= DEFAULT_CLK_DIV;
      rx_ie   <= 1'b0;
      tx_ie   <= 1'b0;
      err_ie  <= 1'b0;
      dbm5    <= 2'(DATA_BITS_RESET - 5);
    end else begin
      if (sel_in && reg_sel == 2'd0 && write_mask_in[0]) clk_div[7:0]  <= write_value_in[7:0];
      if (sel_in && reg_sel == 2'd0 && write_mask_in[1]) clk_div[15:8] <= write_value_in[15:8];
      if (wr_ctrl) begin
        rx_ie  <= write_value_in[0];
        tx_ie  <= write_value_in[1];
        err_ie <= write_value_in[2];
        dbm5   <= write_value_in[4:3];
      end
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_en  <= 1'b0;
      parity_odd <= 1'b0;
    end else if (wr_ctrl) begin
      parity_en  <= write_value_in[5];
      parity_odd <= write_value_in[6];
    end
  end
`else
  assign parity_en  = 1'b0;
  assign parity_odd = 1'b0;
`endif

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp, rx_cnt;
  logic          rx_full, rx_nonempty, rx_pop, rx_push, rx_push_ok;
  logic [7:0]    rx_sh;
  assign rx_cnt      = rx_wp - rx_rp;
  assign rx_full     = rx_cnt == PW'(FIFO_DEPTH);
  assign rx_nonempty = rx_cnt != '0;
  assign rx_pop      = data_rd && rx_nonempty;
  assign rx_push_ok  = rx_push && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push_ok) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)     rx_rp <= rx_rp + PW'(1);
    end
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, tx_cnt_f;
  logic          tx_full, tx_nonempty, tx_pop, tx_push_ok, tx_empty;
  logic [7:0]    tx_head;
  tx_state_t     tx_state;
  logic [15:0]   tx_cnt;
  assign tx_cnt_f    = tx_wp - tx_rp;
  assign tx_full     = tx_cnt_f == PW'(FIFO_DEPTH);
  assign tx_nonempty = tx_cnt_f != '0;
  assign tx_head     = tx_mem[tx_rp[AW-1:0]];
  // The shifter takes a new byte when idle or at the end of a stop bit.
  assign tx_pop      = tx_nonempty &&
                       (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == 16'd0));
  assign tx_push_ok  = data_wr && (!tx_full || tx_pop);
  assign tx_empty    = !tx_nonempty && tx_state == TX_IDLE;

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wp[AW-1:0]] <= write_value_in[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push_ok) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)     tx_rp <= tx_rp + PW'(1);
    end
  end

  // TX engine: start, data LSB first, optional parity, stop
  logic [7:0] tx_sh;
  logic [2:0] tx_idx;
  logic       tx_par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_sh    <= 8'd0;
      tx_idx   <= 3'd0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      if (tx_nonempty) begin
        tx_sh    <= tx_head;
        tx_cnt   <= clk_div;
        tx_out   <= 1'b0;
        tx_state <= TX_START;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= clk_div;
      case (tx_state)
        TX_START: begin
          tx_out   <= tx_sh[0];
          tx_par   <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_idx   <= 3'd0;
          tx_state <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_idx == dbm1) begin
            if (parity_en) begin
              tx_out   <= tx_par ^ parity_odd;
              tx_state <= TX_PAR;
            end else begin
              tx_out   <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            tx_out <= tx_sh[0];
            tx_par <= tx_par ^ tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 3'd1;
          end
        end
        TX_PAR: begin
          tx_out   <= 1'b1;
          tx_state <= TX_STOP;
        end
        TX_STOP: begin
          // Back-to-back: next start bit follows the stop bit directly.
          if (tx_nonempty) begin
            tx_sh    <= tx_head;
            tx_out   <= 1'b0;
            tx_state <= TX_START;
          end else begin
            tx_out   <= 1'b1;
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX engine: centre sampling after half-period start qualification
  rx_state_t   rx_state;
  logic [15:0] rx_cnt_b;
  logic [2:0]  rx_idx;
  logic        rx_par, rx_s, rx_tick;
  logic [1:0]  rx_sync;
  logic        frame_set, par_set;
  assign rx_s      = rx_sync[1];
  assign rx_tick   = rx_cnt_b == 16'd0;
  assign rx_push   = rx_state == RX_STOP && rx_tick && rx_s;
  assign frame_set = rx_state == RX_STOP && rx_tick && !rx_s;
`ifdef UART_PARITY_EN
  assign par_set   = rx_state == RX_PAR && rx_tick && (rx_s != (rx_par ^ parity_odd));
`else
  assign par_set   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt_b <= 16'd0;
      rx_idx   <= 3'd0;
      rx_par   <= 1'b0;
      rx_sh    <= 8'd0;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_cnt_b <= clk_div >> 1;
          rx_state <= RX_START;
        end
        RX_WAIT: if (rx_s) rx_state <= RX_IDLE;
        default: begin
          if (!rx_tick) begin
            rx_cnt_b <= rx_cnt_b - 16'd1;
          end else begin
            rx_cnt_b <= clk_div;
            case (rx_state)
              RX_START: begin
                rx_sh    <= 8'd0;
                rx_par   <= 1'b0;
                rx_idx   <= 3'd0;
                rx_state <= rx_s ? RX_IDLE : RX_DATA;
              end
              RX_DATA: begin
                rx_sh[rx_idx] <= rx_s;
                rx_par        <= rx_par ^ rx_s;
                rx_idx        <= rx_idx + 3'd1;
                if (rx_idx == dbm1) rx_state <= parity_en ? RX_PAR : RX_STOP;
              end
              RX_PAR:  rx_state <= RX_STOP;
              RX_STOP: rx_state <= rx_s ? RX_IDLE : RX_WAIT;
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Sticky flags: write-1-to-clear, a same-cycle set wins
  logic rx_overrun, frame_err, tx_overflow, parity_err;
  logic [3:0] clr;
  assign clr = wr_status ? write_value_in[7:4] : 4'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_overrun  <= (rx_overrun  && !clr[0]) || (rx_push && !rx_push_ok);
      frame_err   <= (frame_err   && !clr[1]) || frame_set;
      tx_overflow <= (tx_overflow && !clr[2]) || (data_wr && !tx_push_ok);
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= (parity_err && !clr[3]) || par_set;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Registered interrupt
  logic [3:0] flags;
  assign flags = {parity_err, tx_overflow, frame_err, rx_overrun};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_out <= 1'b0;
    else        irq_out <= (rx_ie && rx_nonempty) || (tx_ie && tx_empty) || (err_ie && |flags);
  end

  // Read mux
  always_comb begin
    read_value_out = 32'd0;
    if (sel_in) begin
      case (reg_sel)
        2'd0: read_value_out = {16'd0, clk_div};
        2'd1: read_value_out = {16'd0, 8'(rx_cnt), flags, rx_full, rx_nonempty, tx_full, tx_empty};
        2'd2: read_value_out = rx_nonempty ? {24'd0, rx_mem[rx_rp[AW-1:0]]} : 32'hFFFF_FFFF;
        default: read_value_out = {25'd0, parity_odd, parity_en, dbm5, err_ie, tx_ie, rx_ie};
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{address_in[31:4], address_in[1:0], write_value_in[31:16],
                         write_mask_in[3:2], rx_par};

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_in, rx_drv, loop_en;
  logic        tx_out, irq_out, sel_in, read_in, ready_out;
  logic [31:0] address_in, read_value_out, write_value_in, rd;
  logic [3:0]  write_mask_in;
  int          n_tests = 0;
  int          n_fail  = 0;

  assign rx_in = loop_en ? tx_out : rx_drv;

  uart_fifo dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .tx_out(tx_out), .irq_out(irq_out),
    .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in),
    .write_value_in(write_value_in), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [3:0] m, input logic [31:0] v);
    @(negedge clk);
    sel_in = 1'b1; read_in = 1'b0; address_in = {28'd0, r, 2'b00};
    write_mask_in = m; write_value_in = v;
    @(negedge clk);
    sel_in = 1'b0; write_mask_in = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] v);
    @(negedge clk);
    sel_in = 1'b1; read_in = 1'b1; address_in = {28'd0, r, 2'b00}; write_mask_in = 4'd0;
    #1 v = read_value_out;
    @(negedge clk);
    sel_in = 1'b0; read_in = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(r, v);
    check(tag, v, exp);
  endtask

  // Checks every cycle of a frame (clk_div=3: 4 clocks per bit), bits LSB first.
  task automatic check_tx_frame(input string tag, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_out === 1'b0) break;
    end
    for (int i = 0; i < nbits * 4; i++) begin
      if (i > 0) @(negedge clk);
      check(tag, 32'(tx_out), 32'(bits[i / 4]));
    end
  endtask

  task automatic send_rx(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = bits[i];
      repeat (4) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    sel_in = 1'b0; read_in = 1'b0; address_in = 32'd0;
    write_mask_in = 4'd0; write_value_in = 32'd0;
    #22 reset = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_irq", 32'(irq_out), 32'd0);
    check("idle_rdata", read_value_out, 32'd0);
    check("idle_ready", 32'(ready_out), 32'd0);
    read_check("rst_status", 2'd1, 32'h0000_0001);
    read_check("rst_clkdiv", 2'd0, 32'd103);
    read_check("rst_ctrl", 2'd3, 32'h0000_0018);
    read_check("rst_data_empty", 2'd2, 32'hFFFF_FFFF);

    // TX 0x55, 8N1 at clk_div=3
    bus_write(2'd0, 4'b0011, 32'h0000_0003);
    read_check("clkdiv_wr", 2'd0, 32'd3);
    bus_write(2'd2, 4'b0001, 32'h0000_0055);
    check_tx_frame("tx_55", 16'({1'b1, 8'h55, 1'b0}), 10);
    read_check("tx_empty_after", 2'd1, 32'h0000_0001);

    // RX 0xA3
    send_rx(16'({1'b1, 8'hA3, 1'b0}), 10);
    read_check("rx_status_1", 2'd1, 32'h0000_0105);
    read_check("rx_a3", 2'd2, 32'h0000_00A3);
    read_check("rx_empty_again", 2'd2, 32'hFFFF_FFFF);

    // Fill RX past depth
    for (int i = 0; i < 17; i++) send_rx(16'({1'b1, 8'(8'h10 + i), 1'b0}), 10);
    read_check("rx_full_ovr", 2'd1, 32'h0000_101D);
    for (int i = 0; i < 16; i++) read_check("rx_order", 2'd2, 32'(8'h10 + i));
    read_check("rx_drained", 2'd1, 32'h0000_0011);
    bus_write(2'd1, 4'b0001, 32'h0000_0010);
    read_check("ovr_cleared", 2'd1, 32'h0000_0001);

    // Framing error, then interrupt enable latency
    send_rx(16'({1'b0, 8'h5A, 1'b0}), 10);
    read_check("frame_err", 2'd1, 32'h0000_0021);
    read_check("frame_no_push", 2'd2, 32'hFFFF_FFFF);
    check("irq_masked", 32'(irq_out), 32'd0);
    bus_write(2'd3, 4'b0001, 32'h0000_001C);
    check("irq_same_cycle", 32'(irq_out), 32'd0);
    @(negedge clk);
    check("irq_next_cycle", 32'(irq_out), 32'd1);
    bus_write(2'd1, 4'b0001, 32'h0000_0020);
    @(negedge clk);
    check("irq_cleared", 32'(irq_out), 32'd0);
    bus_write(2'd3, 4'b0001, 32'h0000_0018);

    // 5 data bits with loopback
    bus_write(2'd3, 4'b0001, 32'h0000_0000);
    loop_en = 1'b1;
    bus_write(2'd2, 4'b0001, 32'h0000_001F);
    check_tx_frame("tx_5bit_1f", 16'({1'b1, 5'h1F, 1'b0}), 7);
    repeat (10) @(negedge clk);
    read_check("loop_1f", 2'd2, 32'h0000_001F);
    bus_write(2'd2, 4'b0001, 32'h0000_00E5);
    check_tx_frame("tx_5bit_e5", 16'({1'b1, 5'h05, 1'b0}), 7);
    repeat (10) @(negedge clk);
    read_check("loop_e5_trunc", 2'd2, 32'h0000_0005);
    loop_en = 1'b0;

`ifdef UART_PARITY_EN
    // Odd parity, loopback then forced bad parity
    bus_write(2'd3, 4'b0001, 32'h0000_0078);
    read_check("ctrl_parity", 2'd3, 32'h0000_0078);
    loop_en = 1'b1;
    bus_write(2'd2, 4'b0001, 32'h0000_0007);
    check_tx_frame("tx_par_07", 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    read_check("par_ok_status", 2'd1, 32'h0000_0105);
    read_check("par_ok_data", 2'd2, 32'h0000_0007);
    send_rx(16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
    read_check("par_err_status", 2'd1, 32'h0000_0185);
    read_check("par_err_data", 2'd2, 32'h0000_0007);
    bus_write(2'd1, 4'b0001, 32'h0000_0080);
    read_check("par_err_clr", 2'd1, 32'h0000_0001);
`else
    bus_write(2'd3, 4'b0001, 32'h0000_0078);
    read_check("ctrl_no_parity", 2'd3, 32'h0000_0018);
`endif
    bus_write(2'd3, 4'b0001, 32'h0000_0018);

    // TX overflow, then reset mid-frame
    send_rx(16'({1'b1, 8'h3C, 1'b0}), 10);
    for (int i = 0; i < 18; i++) bus_write(2'd2, 4'b0001, 32'h0000_0000);
    read_check("tx_full_ovf", 2'd1, 32'h0000_0146);
    for (int i = 0; i < 50; i++) begin
      if (tx_out === 1'b0) break;
      @(negedge clk);
    end
    check("mid_frame_low", 32'(tx_out), 32'd0);
    #2 reset = 1'b0;
    sel_in = 1'b1; address_in = 32'h4;
    #1 check("rst_async_tx", 32'(tx_out), 32'd1);
    check("rst_async_status", read_value_out, 32'h0000_0001);
    address_in = 32'h8;
    #1 check("rst_async_rx_empty", read_value_out, 32'hFFFF_FFFF);
    sel_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_tx_idle", 32'(tx_out), 32'd1);
    read_check("post_rst_status", 2'd1, 32'h0000_0001);
    read_check("post_rst_clkdiv", 2'd0, 32'd103);
    read_check("post_rst_ctrl", 2'd3, 32'h0000_0018);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
